// File: rtl/uart_pkg.sv
// ----------------------------------------------------------------------------
// uart_pkg
// Shared types and default constants for the UART baud-tick generator.
//   DIV_W     : default integer divisor width
//   FRAC_W    : default fractional divisor width
//   RESET_DIV : divisor loaded at reset (115200 baud from a 50 MHz clock)
//   rx_state_e, tx_state_e : channel FSM state encodings
// ----------------------------------------------------------------------------
package uart_pkg;

    localparam int unsigned DIV_W  = 16;
    localparam int unsigned FRAC_W = 4;
    localparam logic [DIV_W-1:0] RESET_DIV = 16'd433;

    typedef enum logic [1:0] {
        RX_IDLE,
        RX_HALF,
        RX_FULL
    } rx_state_e;

    typedef enum logic {
        TX_IDLE,
        TX_RUN
    } tx_state_e;

endpackage

// File: rtl/uart_baud_gen_if.sv
// ----------------------------------------------------------------------------
// uart_baud_gen_if
// Control/tick bundle of the baud-tick generator.
//   master : drives baud_div, baud_frac, div_wr, tx_en, rx_en, rx_resync;
//            observes tx_tick, rx_tick, rx_half
//   slave  : the generator side (mirror of master)
// ----------------------------------------------------------------------------
interface uart_baud_gen_if #(
    parameter int unsigned DIV_W  = uart_pkg::DIV_W,
    parameter int unsigned FRAC_W = uart_pkg::FRAC_W
);

    logic [DIV_W-1:0]  baud_div;
    logic [FRAC_W-1:0] baud_frac;
    logic              div_wr;
    logic              tx_en;
    logic              rx_en;
    logic              rx_resync;
    logic              tx_tick;
    logic              rx_tick;
    logic              rx_half;

    modport master (
        output baud_div, baud_frac, div_wr, tx_en, rx_en, rx_resync,
        input  tx_tick, rx_tick, rx_half
    );

    modport slave (
        input  baud_div, baud_frac, div_wr, tx_en, rx_en, rx_resync,
        output tx_tick, rx_tick, rx_half
    );

endinterface

// File: rtl/uart_baud_chan.sv
// ----------------------------------------------------------------------------
// uart_baud_chan
// One baud counter: counts up to a supplied terminal value, then restarts
// and emits a registered one-cycle tick.
// Optional feature macro: UART_BAUD_FRAC_EN (fractional accumulator).
// Ports:
//   clock, reset   : clock, async active-low reset
//   run            : channel active; when low the counter/tick are cleared
//   restart        : restart the period from zero (no tick this cycle)
//   term           : terminal count of the current period
//   frac, frac_en  : (UART_BAUD_FRAC_EN only) fraction and its enable
//   hit            : combinational, this cycle ends the period with a tick
//   tick           : registered tick pulse
// ----------------------------------------------------------------------------
module uart_baud_chan #(
    parameter int unsigned DIV_W = uart_pkg::DIV_W
`ifdef UART_BAUD_FRAC_EN
    ,
    parameter int unsigned FRAC_W = uart_pkg::FRAC_W
`endif
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             run,
    input  logic             restart,
    input  logic [DIV_W-1:0] term,
`ifdef UART_BAUD_FRAC_EN
    input  logic [FRAC_W-1:0] frac,
    input  logic              frac_en,
`endif
    output logic             hit,
    output logic             tick
);

    logic [DIV_W-1:0] count;
    logic             at_term;

    assign at_term = (count == term);

`ifdef UART_BAUD_FRAC_EN
    logic [FRAC_W-1:0] acc;
    logic [FRAC_W:0]   acc_sum;
    logic              extra;    // stretch cycle already spent this period
    logic              stretch;

    // A carry out of acc+frac lengthens this period by holding the
    // counter at its terminal for one extra cycle, so the count never
    // has to exceed term (no wrap for term = all ones).
    always_comb begin
        acc_sum = {1'b0, acc} + {1'b0, frac};
        stretch = frac_en && acc_sum[FRAC_W] && !extra;
    end

    assign hit = run && !restart && at_term && !stretch;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            acc   <= '0;
            extra <= 1'b0;
        end else if (!run || restart) begin
            acc   <= '0;
            extra <= 1'b0;
        end else if (at_term) begin
            if (stretch) begin
                extra <= 1'b1;
            end else begin
                extra <= 1'b0;
                if (frac_en) begin
                    acc <= acc_sum[FRAC_W-1:0];
                end
            end
        end
    end
`else
    assign hit = run && !restart && at_term;
`endif

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            count <= '0;
            tick  <= 1'b0;
        end else begin
            tick <= hit;
            if (!run || restart || hit) begin
                count <= '0;
            end else if (!at_term) begin
                count <= count + 1'b1;
            end
        end
    end

endmodule

// File: rtl/uart_baud_gen.sv
// ----------------------------------------------------------------------------
// uart_baud_gen
// Baud-tick generator with independent TX and RX channels and a shadowed,
// runtime-programmable divisor (bit period = div+1 clocks).
// Optional feature macro: UART_BAUD_FRAC_EN (fractional divisor).
// Ports:
//   clock : system clock, rising edge
//   reset : asynchronous active-low reset
//   bus   : uart_baud_gen_if.slave
//           baud_div/baud_frac/div_wr : pending-divisor write
//           tx_en, rx_en              : channel enables (level)
//           rx_resync                 : restart RX at half-period phase
//           tx_tick, rx_tick, rx_half : registered outputs
// ----------------------------------------------------------------------------
module uart_baud_gen #(
    parameter int unsigned      DIV_W     = uart_pkg::DIV_W,
    parameter int unsigned      FRAC_W    = uart_pkg::FRAC_W,
    parameter logic [DIV_W-1:0] RESET_DIV = uart_pkg::RESET_DIV
) (
    input  logic            clock,
    input  logic            reset,
    uart_baud_gen_if.slave  bus
);

    import uart_pkg::*;

    logic [DIV_W-1:0] pend_div;
    logic [DIV_W-1:0] next_div;
    logic [DIV_W-1:0] tx_div;
    logic [DIV_W-1:0] rx_div;
    logic [DIV_W-1:0] rx_term;

    tx_state_e tx_state, tx_next;
    rx_state_e rx_state, rx_next;

    logic tx_load, tx_run, tx_hit, tx_tick;
    logic rx_load, rx_run, rx_hit, rx_tick, rx_restart;

    // A write landing on a terminal count is forwarded so it governs the
    // very next period instead of the one after.
    assign next_div = bus.div_wr ? bus.baud_div : pend_div;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            pend_div <= RESET_DIV;
        end else if (bus.div_wr) begin
            pend_div <= bus.baud_div;
        end
    end

    // ------------------------------------------------------------------ TX
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            tx_state <= TX_IDLE;
        end else begin
            tx_state <= tx_next;
        end
    end

    always_comb begin
        tx_next = tx_state;
        tx_load = 1'b0;
        case (tx_state)
            TX_IDLE: begin
                if (bus.tx_en) begin
                    tx_next = TX_RUN;
                    tx_load = 1'b1;
                end
            end
            TX_RUN: begin
                if (!bus.tx_en) begin
                    tx_next = TX_IDLE;
                end else if (tx_hit) begin
                    tx_load = 1'b1;
                end
            end
            default: tx_next = TX_IDLE;
        endcase
    end

    // Gating with the enable makes the counter/tick clear on the same edge
    // that samples the enable low.
    assign tx_run = (tx_state == TX_RUN) && bus.tx_en;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            tx_div <= RESET_DIV;
        end else if (tx_load) begin
            tx_div <= next_div;
        end
    end

    // ------------------------------------------------------------------ RX
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            rx_state <= RX_IDLE;
        end else begin
            rx_state <= rx_next;
        end
    end

    always_comb begin
        rx_next    = rx_state;
        rx_load    = 1'b0;
        rx_restart = 1'b0;
        if (!bus.rx_en) begin
            rx_next = RX_IDLE;
        end else if (rx_state == RX_IDLE || bus.rx_resync) begin
            // resync outranks a coincident terminal count
            rx_next    = RX_HALF;
            rx_load    = 1'b1;
            rx_restart = bus.rx_resync;
        end else if (rx_hit) begin
            rx_next = RX_FULL;
            rx_load = 1'b1;
        end
    end

    assign rx_run  = (rx_state != RX_IDLE) && bus.rx_en;
    assign rx_term = (rx_state == RX_HALF) ? (rx_div >> 1) : rx_div;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            rx_div <= RESET_DIV;
        end else if (rx_load) begin
            rx_div <= next_div;
        end
    end

    // ------------------------------------------------------------ fraction
`ifdef UART_BAUD_FRAC_EN
    logic [FRAC_W-1:0] pend_frac;
    logic [FRAC_W-1:0] next_frac;
    logic [FRAC_W-1:0] tx_frac;
    logic [FRAC_W-1:0] rx_frac;

    assign next_frac = bus.div_wr ? bus.baud_frac : pend_frac;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            pend_frac <= '0;
            tx_frac   <= '0;
            rx_frac   <= '0;
        end else begin
            if (bus.div_wr) pend_frac <= bus.baud_frac;
            if (tx_load)    tx_frac   <= next_frac;
            if (rx_load)    rx_frac   <= next_frac;
        end
    end
`else
    logic [FRAC_W-1:0] unused_frac;
    assign unused_frac = bus.baud_frac;
`endif

    // ------------------------------------------------------------ channels
    uart_baud_chan #(
        .DIV_W  (DIV_W)
`ifdef UART_BAUD_FRAC_EN
        ,
        .FRAC_W (FRAC_W)
`endif
    ) u_tx_chan (
        .clock   (clock),
        .reset   (reset),
        .run     (tx_run),
        .restart (1'b0),
        .term    (tx_div),
`ifdef UART_BAUD_FRAC_EN
        .frac    (tx_frac),
        .frac_en (1'b1),
`endif
        .hit     (tx_hit),
        .tick    (tx_tick)
    );

    uart_baud_chan #(
        .DIV_W  (DIV_W)
`ifdef UART_BAUD_FRAC_EN
        ,
        .FRAC_W (FRAC_W)
`endif
    ) u_rx_chan (
        .clock   (clock),
        .reset   (reset),
        .run     (rx_run),
        .restart (rx_restart),
        .term    (rx_term),
`ifdef UART_BAUD_FRAC_EN
        .frac    (rx_frac),
        .frac_en (rx_state == RX_FULL),
`endif
        .hit     (rx_hit),
        .tick    (rx_tick)
    );

    assign bus.tx_tick = tx_tick;
    assign bus.rx_tick = rx_tick;
    assign bus.rx_half = (rx_state == RX_HALF);

endmodule

// File: tb/tb_uart_baud_gen.sv
// ----------------------------------------------------------------------------
// tb_uart_baud_gen
// Directed bench for uart_baud_gen. Inputs change and outputs are sampled
// 1 ns after each rising edge. Cycle n of a window is the n-th rising edge
// after the edge that samples the enable.
// Optional feature macro: UART_BAUD_FRAC_EN (adds the fractional-period case).
// ----------------------------------------------------------------------------
module tb_uart_baud_gen;

    logic clock;
    logic reset;

    int checks = 0;
    int errors = 0;

    uart_baud_gen_if #(.DIV_W(16), .FRAC_W(4)) bus ();

    uart_baud_gen #(
        .DIV_W     (16),
        .FRAC_W    (4),
        .RESET_DIV (16'd433)
    ) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check_eq(input string tag, input logic [31:0] got,
                            input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic prog_div(input int d, input int f);
        bus.baud_div  = 16'(d);
        bus.baud_frac = 4'(f);
        bus.div_wr    = 1'b1;
        step();
        bus.div_wr    = 1'b0;
    endtask

    task automatic wait_tx_tick(input int limit, output int pos);
        int n;
        n   = 0;
        pos = -1;
        while (pos < 0 && n < limit) begin
            step();
            n++;
            if (bus.tx_tick === 1'b1) pos = n;
        end
    endtask

    initial begin
        #1ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int pos;
        int ticks;

        reset         = 1'b0;
        bus.baud_div  = '0;
        bus.baud_frac = '0;
        bus.div_wr    = 1'b0;
        bus.tx_en     = 1'b1;
        bus.rx_en     = 1'b0;
        bus.rx_resync = 1'b0;

        // reset held with tx_en high: all outputs stay low
        repeat (3) begin
            step();
            check_eq("rst_tx_tick", bus.tx_tick, 0);
            check_eq("rst_rx_tick", bus.rx_tick, 0);
            check_eq("rst_rx_half", bus.rx_half, 0);
        end

        // reset divisor 433 -> first tick 434 cycles after entering RUN
        reset = 1'b1;
        step();
        check_eq("tx_enter_no_tick", bus.tx_tick, 0);
        wait_tx_tick(600, pos);
        check_eq("tx_first_tick_433", pos, 434);
        bus.tx_en = 1'b0;
        step();
        check_eq("tx_disable_clears", bus.tx_tick, 0);

        // divisor 9: ticks at 10, 20, 30
        prog_div(9, 0);
        bus.tx_en = 1'b1;
        step();
        for (int n = 1; n <= 30; n++) begin
            step();
            check_eq($sformatf("tx_div9_c%0d", n), bus.tx_tick, (n % 10 == 0));
        end
        bus.tx_en = 1'b0;
        step();
        check_eq("tx_off", bus.tx_tick, 0);

        // RX: half period 5, then every 10
        bus.rx_en = 1'b1;
        step();
        check_eq("rx_enter_half", bus.rx_half, 1);
        check_eq("rx_enter_tick", bus.rx_tick, 0);
        for (int n = 1; n <= 25; n++) begin
            step();
            check_eq($sformatf("rx_tick_c%0d", n), bus.rx_tick,
                     (n == 5 || n == 15 || n == 25));
            check_eq($sformatf("rx_half_c%0d", n), bus.rx_half, (n < 5));
        end
        bus.rx_en = 1'b0;
        step();
        check_eq("rx_off_half", bus.rx_half, 0);
        check_eq("rx_off_tick", bus.rx_tick, 0);

        // resync on the cycle of the tick at 15: ticks at 5, 20, 30, 40
        bus.rx_en = 1'b1;
        step();
        for (int n = 1; n <= 40; n++) begin
            bus.rx_resync = (n == 15);
            step();
            bus.rx_resync = 1'b0;
            check_eq($sformatf("rs_tick_c%0d", n), bus.rx_tick,
                     (n == 5 || n == 20 || n == 30 || n == 40));
            check_eq($sformatf("rs_half_c%0d", n), bus.rx_half,
                     (n < 5 || (n >= 15 && n < 20)));
        end
        bus.rx_en = 1'b0;
        step();

        // resync with rx_en low is ignored
        bus.rx_resync = 1'b1;
        step();
        bus.rx_resync = 1'b0;
        check_eq("rs_disabled_half", bus.rx_half, 0);
        step();
        check_eq("rs_disabled_tick", bus.rx_tick, 0);

        // div 9 running; write 4 mid-period (c4), then 6 on a terminal (c20)
        bus.tx_en = 1'b1;
        step();
        for (int n = 1; n <= 34; n++) begin
            if (n == 4) begin
                bus.baud_div = 16'd4;
                bus.div_wr   = 1'b1;
            end else if (n == 20) begin
                bus.baud_div = 16'd6;
                bus.div_wr   = 1'b1;
            end else begin
                bus.div_wr   = 1'b0;
            end
            step();
            check_eq($sformatf("tx_chg_c%0d", n), bus.tx_tick,
                     (n == 10 || n == 15 || n == 20 || n == 27 || n == 34));
        end
        bus.div_wr = 1'b0;
        bus.tx_en  = 1'b0;
        step();

        // divisor 0: TX tick every cycle; RX first tick 1 cycle after HALF
        prog_div(0, 0);
        bus.tx_en = 1'b1;
        bus.rx_en = 1'b1;
        step();
        check_eq("div0_rx_half", bus.rx_half, 1);
        check_eq("div0_tx_enter", bus.tx_tick, 0);
        for (int n = 1; n <= 4; n++) begin
            step();
            check_eq($sformatf("div0_tx_c%0d", n), bus.tx_tick, 1);
            check_eq($sformatf("div0_rx_c%0d", n), bus.rx_tick, 1);
            check_eq($sformatf("div0_half_c%0d", n), bus.rx_half, 0);
        end
        bus.tx_en = 1'b0;
        bus.rx_en = 1'b0;
        step();
        check_eq("div0_tx_off", bus.tx_tick, 0);
        check_eq("div0_rx_off", bus.rx_tick, 0);

        // async reset while a tick is high, and mid-period afterwards
        prog_div(9, 0);
        bus.tx_en = 1'b1;
        step();
        for (int n = 1; n <= 10; n++) step();
        check_eq("pre_reset_tick", bus.tx_tick, 1);
        #1;
        reset = 1'b0;
        #1;
        check_eq("async_clear", bus.tx_tick, 0);
        ticks = 0;
        repeat (12) begin
            step();
            if (bus.tx_tick === 1'b1) ticks++;
        end
        check_eq("no_tick_in_reset", ticks, 0);
        reset = 1'b1;
        step();
        wait_tx_tick(600, pos);
        check_eq("div_restored_by_reset", pos, 434);
        bus.tx_en = 1'b0;
        step();

`ifdef UART_BAUD_FRAC_EN
        // div 9, frac 8/16: periods alternate 10, 11; 32 periods = 336
        begin
            int tpos [32];
            int cnt;
            int n;
            foreach (tpos[i]) tpos[i] = 0;
            prog_div(9, 8);
            bus.tx_en = 1'b1;
            step();
            cnt = 0;
            n   = 0;
            while (cnt < 32 && n < 500) begin
                step();
                n++;
                if (bus.tx_tick === 1'b1) begin
                    tpos[cnt] = n;
                    cnt++;
                end
            end
            check_eq("frac_tick_count", cnt, 32);
            check_eq("frac_first_period", tpos[0], 10);
            check_eq("frac_second_period", tpos[1], 21);
            check_eq("frac_32_periods", tpos[31], 336);
            bus.tx_en = 1'b0;
            step();
        end
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
